// File: rtl/key_pkg.sv
// Shared event encoding and hold-FSM state type for the key event queue.
package key_pkg;

    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_RELEASE = 2'b01;
    localparam logic [1:0] EV_LONG    = 2'b10;
    localparam logic [1:0] EV_REPEAT  = 2'b11;

    localparam int EV_TYPE_MSB = 7;
    localparam int EV_TYPE_LSB = 6;
    localparam int EV_IDX_MSB  = 5;
    localparam int EV_IDX_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2,
        ST_DONE = 2'd3
    } hold_state_t;

    function automatic logic [7:0] mk_event(input logic [1:0] ev_type, input logic [5:0] idx);
        logic [7:0] ev;
        ev = '0;
        ev[EV_TYPE_MSB:EV_TYPE_LSB] = ev_type;
        ev[EV_IDX_MSB:EV_IDX_LSB]   = idx;
        return ev;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// First-word fall-through event FIFO with occupancy count; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module key_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_do;
    logic             push_do;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_do  = pop && !empty;
    assign push_do = push && (!full || pop_do);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_do) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_do) wr_ptr <= wr_ptr + AW'(1);
            if (pop_do)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_do, pop_do})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// Turns debounced key levels into PRESS/RELEASE/LONG/REPEAT events queued for the CPU.
// KEY_REPEAT_EN enables REPEAT events after LONG; otherwise the hold FSM parks in DONE.
//   state   | meaning
//   IDLE    | no key tracked
//   HOLD    | counting towards LONG for held_idx
//   RPT     | counting REPEAT periods (KEY_REPEAT_EN)
//   DONE    | LONG sent, waiting for release (no KEY_REPEAT_EN)
module key_event_queue
    import key_pkg::*;
#(
    parameter int NKEYS      = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 26,
    parameter int LONG_CYC   = 25_000_000,
    parameter int REPEAT_CYC = 5_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NKEYS-1:0]              key_level,
    input  logic                          rd_en,
    output logic                          ev_valid,
    output logic [7:0]                    ev_data,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          ovf,
    input  logic                          ovf_clr
);

    if (NKEYS < 1 || NKEYS > 64 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || LONG_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_cfg
        $error("key_event_queue: illegal parameter set");
    end

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST      = CNT_W'(REPEAT_CYC - 1);
    localparam hold_state_t      ST_AFTER_LONG = ST_RPT;
`else
    localparam hold_state_t      ST_AFTER_LONG = ST_DONE;
`endif

    function automatic logic [NKEYS-1:0] lowest_oh(input logic [NKEYS-1:0] v);
        return v & (~v + NKEYS'(1));
    endfunction

    function automatic logic [5:0] oh_idx(input logic [NKEYS-1:0] oh);
        logic [5:0] idx;
        idx = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (oh[i]) idx = 6'(i);
        end
        return idx;
    endfunction

    logic             armed;
    logic [NKEYS-1:0] lvl_q, pend_press, pend_rel;
    logic [NKEYS-1:0] rise, fall, rise_oh, press_oh, rel_oh;
    logic [NKEYS-1:0] gnt_press, gnt_rel, held_oh;
    logic             held_rel, pend_hold, gnt_hold, fire, push, pop, ovf_set;
    logic             fifo_empty, fifo_full;
    logic [1:0]       fire_type;
    logic [7:0]       hold_data, push_data;
    logic [5:0]       held_idx;
    logic [CNT_W-1:0] cnt;
    hold_state_t      state;

    // the first cycle after reset only samples, so keys held through reset stay silent
    assign rise     = armed ? (key_level & ~lvl_q) : '0;
    assign fall     = armed ? (~key_level & lvl_q) : '0;
    assign rise_oh  = lowest_oh(rise);
    assign press_oh = lowest_oh(pend_press);
    assign rel_oh   = lowest_oh(pend_rel);
    assign held_rel = |(held_oh & ~key_level);
    assign pop      = rd_en && !fifo_empty;
    assign ev_valid = !fifo_empty;

    always_comb begin
        gnt_hold  = 1'b0;
        gnt_press = '0;
        gnt_rel   = '0;
        push_data = '0;
        if (!fifo_full || pop) begin
            if (pend_hold) begin
                gnt_hold  = 1'b1;
                push_data = hold_data;
            end else if (|pend_press) begin
                gnt_press = press_oh;
                push_data = mk_event(EV_PRESS, oh_idx(press_oh));
            end else if (|pend_rel) begin
                gnt_rel   = rel_oh;
                push_data = mk_event(EV_RELEASE, oh_idx(rel_oh));
            end
        end
        push = gnt_hold || (|gnt_press) || (|gnt_rel);
    end

    always_comb begin
        fire      = 1'b0;
        fire_type = EV_LONG;
        if (!(|rise) && !held_rel) begin
            if (state == ST_HOLD && cnt == LONG_LAST) begin
                fire = 1'b1;
            end
`ifdef KEY_REPEAT_EN
            else if (state == ST_RPT && cnt == RPT_LAST) begin
                fire      = 1'b1;
                fire_type = EV_REPEAT;
            end
`endif
        end
    end

    assign ovf_set = (|(rise & pend_press & ~gnt_press))
                   || (|(fall & pend_rel & ~gnt_rel))
                   || (fire && pend_hold && !gnt_hold);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed      <= 1'b0;
            lvl_q      <= '0;
            pend_press <= '0;
            pend_rel   <= '0;
            ovf        <= 1'b0;
        end else begin
            armed      <= 1'b1;
            lvl_q      <= key_level;
            pend_press <= (pend_press & ~gnt_press) | rise;
            pend_rel   <= (pend_rel & ~gnt_rel) | fall;
            ovf        <= ovf_set || (ovf && !ovf_clr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            held_oh   <= '0;
            held_idx  <= '0;
            pend_hold <= 1'b0;
            hold_data <= '0;
        end else begin
            if (fire) begin
                pend_hold <= 1'b1;
                hold_data <= mk_event(fire_type, held_idx);
            end else if (gnt_hold) begin
                pend_hold <= 1'b0;
            end

            // a new press always takes over tracking, even while the old key releases
            if (|rise) begin
                state    <= ST_HOLD;
                cnt      <= '0;
                held_oh  <= rise_oh;
                held_idx <= oh_idx(rise_oh);
            end else if (state != ST_IDLE && held_rel) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                held_oh <= '0;
            end else begin
                case (state)
                    ST_HOLD: begin
                        if (fire) begin
                            state <= ST_AFTER_LONG;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
`ifdef KEY_REPEAT_EN
                    ST_RPT: begin
                        if (fire) cnt <= '0;
                        else      cnt <= cnt + CNT_W'(1);
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    key_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .rd_data   (ev_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (ev_count)
    );

endmodule

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue against a queue-based reference model.
module tb_key_event_queue;

    localparam int NK  = 8;
    localparam int DEP = 4;
    localparam int LNG = 16;
    localparam int RPT = 4;
`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NK-1:0] keys = '0;
    logic          rd_en = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          ev_valid;
    logic [7:0]    ev_data;
    logic [2:0]    ev_count;
    logic          ovf;
    logic [12:0]   dut_out;

    int n_tests = 0;
    int n_fail  = 0;
    bit [7:0] popped[$];

    key_event_queue #(
        .NKEYS(NK), .FIFO_DEPTH(DEP), .CNT_W(8), .LONG_CYC(LNG), .REPEAT_CYC(RPT)
    ) dut (
        .clk(clk), .rst(rst), .key_level(keys), .rd_en(rd_en),
        .ev_valid(ev_valid), .ev_data(ev_data), .ev_count(ev_count),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;
    assign dut_out = {ev_valid, ev_data, ev_count, ovf};

    // reference model: event queue, pending sets and hold age in cycles
    bit [7:0]   mq[$];
    bit [NK-1:0] m_lvl, m_pp, m_pr;
    bit         m_armed, m_ph, m_ovf, m_held;
    bit [7:0]   m_hd;
    int         m_hkey, m_age;

    function automatic void model_reset();
        mq.delete();
        m_lvl = '0; m_pp = '0; m_pr = '0;
        m_armed = 0; m_ph = 0; m_ovf = 0; m_held = 0;
        m_hd = '0; m_hkey = 0; m_age = 0;
    endfunction

    function automatic void model_step(input bit [NK-1:0] kl, input bit rd, input bit clr);
        bit pop_now, can_push, coal, fire, gh;
        bit [NK-1:0] rise, fall;
        bit [1:0] ft;
        bit [7:0] pushv;
        int gp, gr;
        pop_now  = rd && (mq.size() > 0);
        can_push = (mq.size() < DEP) || pop_now;
        gp = -1; gr = -1; gh = 0; coal = 0; fire = 0; ft = 2'b10; pushv = '0;
        rise = m_armed ? (kl & ~m_lvl) : '0;
        fall = m_armed ? (~kl & m_lvl) : '0;
        if (can_push) begin
            if (m_ph) gh = 1;
            else begin
                for (int i = NK - 1; i >= 0; i--) if (m_pp[i]) gp = i;
                if (gp < 0) for (int i = NK - 1; i >= 0; i--) if (m_pr[i]) gr = i;
            end
        end
        if (gh) begin pushv = m_hd; m_ph = 0; end
        else if (gp >= 0) begin pushv = {2'b00, 6'(gp)}; m_pp[gp] = 0; end
        else if (gr >= 0) begin pushv = {2'b01, 6'(gr)}; m_pr[gr] = 0; end
        for (int i = 0; i < NK; i++) begin
            if (rise[i]) begin if (m_pp[i]) coal = 1; m_pp[i] = 1; end
            if (fall[i]) begin if (m_pr[i]) coal = 1; m_pr[i] = 1; end
        end
        if (rise != '0) begin
            m_held = 1; m_age = 0;
            for (int i = NK - 1; i >= 0; i--) if (rise[i]) m_hkey = i;
        end else if (m_held && !kl[m_hkey]) begin
            m_held = 0;
        end else if (m_held) begin
            m_age++;
            if (m_age == LNG) fire = 1;
            else if (REP_EN && m_age > LNG && ((m_age - LNG) % RPT) == 0) begin
                fire = 1; ft = 2'b11;
            end
        end
        if (fire) begin
            if (m_ph) coal = 1;
            m_ph = 1;
            m_hd = {ft, 6'(m_hkey)};
        end
        if (coal) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (pop_now) void'(mq.pop_front());
        if (gh || gp >= 0 || gr >= 0) mq.push_back(pushv);
        m_lvl = kl;
        m_armed = 1;
    endfunction

    function automatic logic [12:0] model_out();
        logic [7:0] d;
        d = (mq.size() > 0) ? mq[0] : 8'h00;
        return {mq.size() > 0, d, 3'(mq.size()), m_ovf};
    endfunction

    function automatic int first_diff(input bit [7:0] exp[$]);
        for (int i = 0; i < exp.size() && i < popped.size(); i++)
            if (popped[i] != exp[i]) return i;
        if (popped.size() != exp.size()) return (exp.size() < popped.size()) ? exp.size() : popped.size();
        return -1;
    endfunction

    task automatic step();
        if (rd_en && ev_valid) popped.push_back(ev_data);
        model_step(keys, rd_en, ovf_clr);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; keys = '0; rd_en = 1'b0; ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (dut_out !== 13'h0) begin
            n_fail++; $display("FAIL reset_state got=%h want=0000", dut_out);
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (dut_out !== model_out()) begin
                n_fail++; $display("FAIL reset_idle c=%0d got=%h want=%h", c, dut_out, model_out());
            end
        end
    endtask

    task automatic test_tap();
        bit [7:0] exp[$];
        int d;
        exp = '{8'h03, 8'h43};
        popped.delete(); rd_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            keys[3] = (c < 5);
            step();
            n_tests++;
            if (dut_out !== model_out()) begin
                n_fail++; $display("FAIL tap c=%0d got=%h want=%h", c, dut_out, model_out());
            end
        end
        d = first_diff(exp);
        n_tests++;
        if (d >= 0) begin
            n_fail++; $display("FAIL tap_seq idx=%0d got_n=%0d want_n=%0d", d, popped.size(), exp.size());
        end
    endtask

    task automatic test_same_cycle();
        bit [7:0] exp[$];
        int d;
        exp = '{8'h02, 8'h05, 8'h45, 8'h82, 8'h42};
        popped.delete(); rd_en = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c == 0) begin keys[2] = 1'b1; keys[5] = 1'b1; end
            if (c == 3) begin keys[5] = 1'b0; rd_en = 1'b1; end
            if (c == 20) keys[2] = 1'b0;
            step();
            n_tests++;
            if (dut_out !== model_out()) begin
                n_fail++; $display("FAIL same_cycle c=%0d got=%h want=%h", c, dut_out, model_out());
            end
            if (c == 2) begin
                n_tests++;
                if (ev_count !== 3'd2 || ev_data !== 8'h02) begin
                    n_fail++; $display("FAIL same_cycle_order count=%0d head=%h want 2/02", ev_count, ev_data);
                end
            end
        end
        d = first_diff(exp);
        n_tests++;
        if (d >= 0) begin
            n_fail++; $display("FAIL same_cycle_seq idx=%0d got_n=%0d want_n=%0d", d, popped.size(), exp.size());
        end
    endtask

    task automatic test_hold();
        bit [7:0] exp[$];
        int d;
        if (REP_EN) exp = '{8'h01, 8'h81, 8'hC1, 8'hC1, 8'hC1, 8'h41};
        else        exp = '{8'h01, 8'h81, 8'h41};
        popped.delete(); rd_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            keys[1] = (c < 30);
            step();
            n_tests++;
            if (dut_out !== model_out()) begin
                n_fail++; $display("FAIL hold c=%0d got=%h want=%h", c, dut_out, model_out());
            end
        end
        d = first_diff(exp);
        n_tests++;
        if (d >= 0) begin
            n_fail++; $display("FAIL hold_seq idx=%0d got_n=%0d want_n=%0d", d, popped.size(), exp.size());
        end
    endtask

    task automatic test_saturate_drain();
        bit [7:0] exp[$];
        int d;
        exp = '{8'h00, 8'h40, 8'h01, 8'h41, 8'h02, 8'h03, 8'h04, 8'h05,
                8'h42, 8'h43, 8'h44, 8'h45};
        rd_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            for (int s = 0; s < 3; s++) begin
                keys[k] = (s < 2);
                step();
                n_tests++;
                if (dut_out !== model_out()) begin
                    n_fail++; $display("FAIL fill k=%0d s=%0d got=%h want=%h", k, s, dut_out, model_out());
                end
            end
        end
        n_tests++;
        if (ev_count !== 3'd4 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL saturate count=%0d ovf=%0b want 4/0", ev_count, ovf);
        end
        popped.delete(); rd_en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            n_tests++;
            if (dut_out !== model_out()) begin
                n_fail++; $display("FAIL drain c=%0d got=%h want=%h", c, dut_out, model_out());
            end
            if (c < 8) begin
                n_tests++;
                if (ev_count !== 3'd4) begin
                    n_fail++; $display("FAIL full_pushpop c=%0d count=%0d want 4", c, ev_count);
                end
            end
        end
        d = first_diff(exp);
        n_tests++;
        if (d >= 0) begin
            n_fail++; $display("FAIL drain_seq idx=%0d got_n=%0d want_n=%0d", d, popped.size(), exp.size());
        end
    endtask

    task automatic test_ovf();
        bit [7:0] exp[$];
        bit [NK-1:0] pat[11];
        bit clr_pat[11];
        int d;
        exp = '{8'h00, 8'h40, 8'h01, 8'h41, 8'h06, 8'h46};
        pat = '{8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h00, 8'h00, 8'h40, 8'h40, 8'h00, 8'h40};
        clr_pat = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        rd_en = 1'b0;
        for (int c = 0; c < 11; c++) begin
            keys = pat[c]; ovf_clr = clr_pat[c];
            step();
            n_tests++;
            if (dut_out !== model_out()) begin
                n_fail++; $display("FAIL ovf_fill c=%0d got=%h want=%h", c, dut_out, model_out());
            end
        end
        n_tests++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%0b want=1", ovf); end
        ovf_clr = 1'b1;
        step();
        n_tests++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got=%0b want=0", ovf); end
        keys[6] = 1'b0;
        step();
        n_tests++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got=%0b want=1", ovf); end
        step();
        n_tests++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr2 got=%0b want=0", ovf); end
        ovf_clr = 1'b0;
        popped.delete(); rd_en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            n_tests++;
            if (dut_out !== model_out()) begin
                n_fail++; $display("FAIL ovf_drain c=%0d got=%h want=%h", c, dut_out, model_out());
            end
        end
        d = first_diff(exp);
        n_tests++;
        if (d >= 0) begin
            n_fail++; $display("FAIL ovf_seq idx=%0d got_n=%0d want_n=%0d", d, popped.size(), exp.size());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2400; c++) begin
            if (c == 1200) begin
                rst = 1'b0;
                #2;
                n_tests++;
                if (dut_out !== 13'h0) begin
                    n_fail++; $display("FAIL mid_reset got=%h want=0000", dut_out);
                end
                model_reset();
                rst = 1'b1;
            end
            if (c < 1200) begin
                for (int i = 0; i < 4; i++) if ($urandom_range(0, 19) == 0) keys[i] = ~keys[i];
            end else begin
                if ($urandom_range(0, 39) == 0) keys[7] = ~keys[7];
                if ($urandom_range(0, 59) == 0) keys[4] = ~keys[4];
            end
            rd_en   = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            step();
            n_tests++;
            if (dut_out !== model_out()) begin
                n_fail++; $display("FAIL random c=%0d got=%h want=%h", c, dut_out, model_out());
            end
        end
        keys = '0; rd_en = 1'b1; ovf_clr = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            n_tests++;
            if (dut_out !== model_out()) begin
                n_fail++; $display("FAIL random_drain c=%0d got=%h want=%h", c, dut_out, model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_tap();
        test_same_cycle();
        test_hold();
        test_saturate_drain();
        test_ovf();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
